wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the single register-file write
// port, shared by the load unit (mem), the ALU (alu) and the link writer (pc).
// Ports:
//   clk, reset          - rising-edge clock, async active-high reset
//   flush               - squashes every grant in the current cycle
//   <src>_valid/rd/data - write-back request from mem, alu or pc
//   <src>_ready         - combinational grant; valid&&ready is the handshake
//   rf_we/rf_rd/rf_wdata/wb_sel - registered write port, one cycle after
//                         the handshake; wb_sel 00 mem, 01 alu, 10 next_pc
module wb_port_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        pc_valid,
   input  logic [4:0]  pc_rd,
   input  logic [31:0] pc_data,
   output logic        pc_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wdata,
   output logic [1:0]  wb_sel
);

   localparam logic [1:0] SEL_MEM = 2'b00;
   localparam logic [1:0] SEL_ALU = 2'b01;
   localparam logic [1:0] SEL_PC  = 2'b10;

   // Pointer names the source with highest priority this cycle (0..2).
   logic [1:0]  ptr_q, ptr_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_rd_q, rf_rd_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;
   logic [1:0]  wb_sel_q, wb_sel_d;

   // One-hot grant: bit 0 mem, bit 1 alu, bit 2 pc.
   logic [2:0]  gnt;
   logic        hs;
   logic [4:0]  win_rd;
   logic [31:0] win_data;
   logic [1:0]  win_sel;
   logic [1:0]  win_next;

   // Search from the pointer upward, wrapping 2 -> 0.  Reset gating keeps
   // ready low while reset is held, even between clock edges.
   always_comb begin
      gnt = 3'b000;
      if (!reset && !flush) begin
         unique case (ptr_q)
            2'd1: begin
               if (alu_valid)      gnt = 3'b010;
               else if (pc_valid)  gnt = 3'b100;
               else if (mem_valid) gnt = 3'b001;
            end
            2'd2: begin
               if (pc_valid)       gnt = 3'b100;
               else if (mem_valid) gnt = 3'b001;
               else if (alu_valid) gnt = 3'b010;
            end
            default: begin
               if (mem_valid)      gnt = 3'b001;
               else if (alu_valid) gnt = 3'b010;
               else if (pc_valid)  gnt = 3'b100;
            end
         endcase
      end
   end

   assign mem_ready = gnt[0];
   assign alu_ready = gnt[1];
   assign pc_ready  = gnt[2];
   assign hs        = |gnt;

   // Winner payload and the pointer value that follows it.
   always_comb begin
      win_rd   = mem_rd;
      win_data = mem_data;
      win_sel  = SEL_MEM;
      win_next = 2'd1;
      if (gnt[1]) begin
         win_rd   = alu_rd;
         win_data = alu_data;
         win_sel  = SEL_ALU;
         win_next = 2'd2;
      end else if (gnt[2]) begin
         win_rd   = pc_rd;
         win_data = pc_data;
         win_sel  = SEL_PC;
         win_next = 2'd0;
      end
   end

   // Writes to x0 are accepted and advance the pointer, but never enable
   // the register file.  Address/data/select still follow the winner.
   always_comb begin
      ptr_d      = ptr_q;
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      wb_sel_d   = wb_sel_q;
      if (hs) begin
         ptr_d      = win_next;
         rf_we_d    = (win_rd != 5'd0);
         rf_rd_d    = win_rd;
         rf_wdata_d = win_data;
         wb_sel_d   = win_sel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q      <= 2'd0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= 32'd0;
         wb_sel_q   <= SEL_MEM;
      end else begin
         ptr_q      <= ptr_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         wb_sel_q   <= wb_sel_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;
   assign wb_sel   = wb_sel_q;

endmodule
